// File: rtl/golden_test_pkg.sv
// Shared result codes, FSM states and result-priority helpers for the golden-test controller.
package golden_test_pkg;

    typedef enum logic [2:0] {
        RES_RUNNING = 3'd0,
        RES_PASS    = 3'd1,
        RES_FAIL    = 3'd2,
        RES_TIMEOUT = 3'd3
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_EVAL = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Codes 4..7 are not defined by the comparators and count as a failure.
    function automatic result_e normResult(input logic [2:0] code);
        result_e res;
        case (code)
            3'd0:    res = RES_RUNNING;
            3'd1:    res = RES_PASS;
            3'd3:    res = RES_TIMEOUT;
            default: res = RES_FAIL;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] resultRank(input result_e res);
        logic [1:0] rank;
        case (res)
            RES_FAIL:    rank = 2'd3;
            RES_TIMEOUT: rank = 2'd2;
            RES_PASS:    rank = 2'd1;
            default:     rank = 2'd0;
        endcase
        return rank;
    endfunction

    function automatic result_e worseResult(input result_e a, input result_e b);
        return (resultRank(b) > resultRank(a)) ? b : a;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/golden_test_ctrl.sv
// Golden-test sequencer: holds channels in reset until lock is stable, runs N_RUNS tests and aggregates results.
// Optional RUN timeout counter enabled by defining GOLDEN_TEST_TIMEOUT_EN.
module golden_test_ctrl
    import golden_test_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int RESET_DELAY    = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int N_RUNS         = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          locked,
    input  logic [N_CH-1:0][2:0]          ch_result,
    output logic [N_CH-1:0]               ch_rst,
    output logic [2:0]                    status,
    output logic [N_CH-1:0]               fail_mask,
    output logic [$clog2(N_RUNS+1)-1:0]   run_cnt,
    output logic                          done
);

    localparam int HOLD_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
    localparam int RUN_W  = $clog2(N_RUNS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_DELAY - 1);
    localparam logic [RUN_W-1:0]  RUNS_MAX  = RUN_W'(N_RUNS);

    logic lockS;

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      holdCnt_q, holdCnt_d;
    logic [N_CH-1:0]        latched_q, latched_d;
    logic [N_CH-1:0][2:0]   latchRes_q, latchRes_d;
    logic [N_CH-1:0]        chRst_q, chRst_d;
    result_e                status_q, status_d;
    logic [N_CH-1:0]        failMask_q, failMask_d;
    logic [RUN_W-1:0]       runCnt_q, runCnt_d;
    logic                   done_q, done_d;

    logic                   allLatched;
    logic                   timeout;
    logic [RUN_W-1:0]       runCntNext;
    logic                   runsComplete;
    result_e                runResult;
    logic [N_CH-1:0]        chNotPass;

    lock_sync u_lock_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (locked),
        .sync_o  (lockS)
    );

`ifdef GOLDEN_TEST_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] toCnt_q, toCnt_d;

    // Counter sits at zero outside RUN, so every run starts counting from zero.
    always_comb begin
        toCnt_d = '0;
        if (state_q == ST_RUN && lockS) begin
            toCnt_d = toCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toCnt_q <= '0;
        end else begin
            toCnt_q <= toCnt_d;
        end
    end

    assign timeout = (state_q == ST_RUN) && (toCnt_q == TO_LAST);
`else
    // No counter in this build: RUN only ends once every channel has reported.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // First non-RUNNING code per channel is captured; latches are wiped outside RUN.
    always_comb begin
        latched_d  = latched_q;
        latchRes_d = latchRes_q;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!latched_q[i] && (ch_result[i] != RES_RUNNING)) begin
                    latched_d[i]  = 1'b1;
                    latchRes_d[i] = normResult(ch_result[i]);
                end
            end
        end else begin
            latched_d  = '0;
            latchRes_d = '0;
        end
        if (!lockS) begin
            latched_d  = '0;
            latchRes_d = '0;
        end
    end

    // A latch landing in the same cycle as the timeout wins over the timeout.
    assign allLatched = &latched_d;

    always_comb begin
        result_e chRes;
        chRes     = RES_RUNNING;
        runResult = RES_PASS;
        chNotPass = '0;
        for (int i = 0; i < N_CH; i++) begin
            chRes        = latched_q[i] ? normResult(latchRes_q[i]) : RES_TIMEOUT;
            chNotPass[i] = (chRes != RES_PASS);
            runResult    = worseResult(runResult, chRes);
        end
    end

    assign runCntNext   = (runCnt_q == RUNS_MAX) ? runCnt_q : runCnt_q + 1'b1;
    assign runsComplete = (runCntNext == RUNS_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        case (state_q)
            ST_IDLE: begin
                holdCnt_d = '0;
                if (lockS) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (holdCnt_q == HOLD_LAST) begin
                    state_d   = ST_RUN;
                    holdCnt_d = '0;
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (allLatched || timeout) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                holdCnt_d = '0;
                state_d   = runsComplete ? ST_DONE : ST_HOLD;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d   = ST_IDLE;
                holdCnt_d = '0;
            end
        endcase
        if (!lockS) begin
            state_d   = ST_IDLE;
            holdCnt_d = '0;
        end
    end

    // Channel reset follows the state being entered so it is registered without extra delay.
    always_comb begin
        chRst_d    = ((state_d == ST_RUN) || (state_d == ST_DONE)) ? '0 : '1;
        status_d   = status_q;
        failMask_d = failMask_q;
        runCnt_d   = runCnt_q;
        done_d     = done_q;
        if (state_q == ST_EVAL) begin
            status_d   = worseResult(status_q, runResult);
            failMask_d = failMask_q | chNotPass;
            runCnt_d   = runCntNext;
            done_d     = runsComplete;
        end
        if (!lockS) begin
            status_d   = RES_RUNNING;
            failMask_d = '0;
            runCnt_d   = '0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            holdCnt_q  <= '0;
            latched_q  <= '0;
            latchRes_q <= '0;
            chRst_q    <= '1;
            status_q   <= RES_RUNNING;
            failMask_q <= '0;
            runCnt_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            holdCnt_q  <= holdCnt_d;
            latched_q  <= latched_d;
            latchRes_q <= latchRes_d;
            chRst_q    <= chRst_d;
            status_q   <= status_d;
            failMask_q <= failMask_d;
            runCnt_q   <= runCnt_d;
            done_q     <= done_d;
        end
    end

    assign ch_rst    = chRst_q;
    assign status    = status_q;
    assign fail_mask = failMask_q;
    assign run_cnt   = runCnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_golden_test_ctrl.sv
// Directed bench for golden_test_ctrl: one single-run and one three-run instance share all inputs.
module tb_golden_test_ctrl;

    logic            clk;
    logic            rst;
    logic            locked;
    logic [3:0][2:0] chResult;

    logic [3:0] chRstA, failMaskA;
    logic [2:0] statusA;
    logic [0:0] runCntA;
    logic       doneA;

    logic [3:0] chRstB, failMaskB;
    logic [2:0] statusB;
    logic [1:0] runCntB;
    logic       doneB;

    int vecCount = 0;
    int errCount = 0;

    golden_test_ctrl #(
        .N_CH(4), .RESET_DELAY(4), .TIMEOUT_CYCLES(16), .N_RUNS(1)
    ) dutA (
        .clk(clk), .rst(rst), .locked(locked), .ch_result(chResult),
        .ch_rst(chRstA), .status(statusA), .fail_mask(failMaskA),
        .run_cnt(runCntA), .done(doneA)
    );

    golden_test_ctrl #(
        .N_CH(4), .RESET_DELAY(4), .TIMEOUT_CYCLES(16), .N_RUNS(3)
    ) dutB (
        .clk(clk), .rst(rst), .locked(locked), .ch_result(chResult),
        .ch_rst(chRstB), .status(statusB), .fail_mask(failMaskB),
        .run_cnt(runCntB), .done(doneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of channel codes (ch3..ch0) and lets the clock sample them.
    task automatic applyStimulus(input logic [2:0] c3, input logic [2:0] c2,
                                 input logic [2:0] c1, input logic [2:0] c0);
        chResult = {c3, c2, c1, c0};
        tick();
    endtask

    task automatic relock();
        locked = 1'b1;
        for (int k = 0; k < 7; k++) tick();
    endtask

    task automatic dropLock();
        locked = 1'b0;
        for (int k = 0; k < 3; k++) tick();
    endtask

    initial begin
        rst      = 1'b1;
        locked   = 1'b0;
        chResult = '0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_chrst", 32'(chRstA), 32'hF);
        checkOutput("rst_status", 32'(statusA), 32'h0);
        checkOutput("rst_failmask", 32'(failMaskA), 32'h0);
        checkOutput("rst_runcnt", 32'(runCntB), 32'h0);
        checkOutput("rst_done", 32'(doneA), 32'h0);

        // Release must land exactly on the 7th edge after locked rises.
        locked = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkOutput($sformatf("release_e%0d", k), 32'(chRstA), (k < 7) ? 32'hF : 32'h0);
        end

        for (int c = 1; c <= 9; c++) begin
            applyStimulus((c >= 9) ? 3'd1 : 3'd0, (c >= 7) ? 3'd1 : 3'd0,
                          (c >= 5) ? 3'd1 : 3'd0, (c >= 3) ? 3'd1 : 3'd0);
            if (c >= 8) checkOutput($sformatf("run1_notdone_c%0d", c), 32'(doneA), 32'h0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("run1_A_status", 32'(statusA), 32'h1);
        checkOutput("run1_A_failmask", 32'(failMaskA), 32'h0);
        checkOutput("run1_A_runcnt", 32'(runCntA), 32'h1);
        checkOutput("run1_A_done", 32'(doneA), 32'h1);
        checkOutput("run1_A_chrst", 32'(chRstA), 32'h0);
        checkOutput("run1_B_runcnt", 32'(runCntB), 32'h1);
        checkOutput("run1_B_status", 32'(statusB), 32'h1);
        checkOutput("run1_B_done", 32'(doneB), 32'h0);
        checkOutput("run1_B_hold0", 32'(chRstB), 32'hF);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput($sformatf("run1_B_hold%0d", k), 32'(chRstB), (k < 4) ? 32'hF : 32'h0);
        end

        // Run 2: ch0 reports an undefined code (counts as FAIL), then PASS which must be ignored.
        applyStimulus(0, 0, 0, 3'd6);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("run2_B_status", 32'(statusB), 32'h2);
        checkOutput("run2_B_failmask", 32'(failMaskB), 32'h1);
        checkOutput("run2_B_runcnt", 32'(runCntB), 32'h2);
        checkOutput("run2_B_chrst", 32'(chRstB), 32'hF);
        checkOutput("run2_A_frozen_status", 32'(statusA), 32'h1);
        checkOutput("run2_A_frozen_done", 32'(doneA), 32'h1);
        for (int k = 0; k < 4; k++) tick();

        applyStimulus(1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("run3_B_status", 32'(statusB), 32'h2);
        checkOutput("run3_B_failmask", 32'(failMaskB), 32'h1);
        checkOutput("run3_B_runcnt", 32'(runCntB), 32'h3);
        checkOutput("run3_B_done", 32'(doneB), 32'h1);
        checkOutput("run3_B_chrst", 32'(chRstB), 32'h0);

        locked = 1'b0;
        tick();
        tick();
        checkOutput("unlock_B_still_done", 32'(doneB), 32'h1);
        tick();
        checkOutput("unlock_B_done", 32'(doneB), 32'h0);
        checkOutput("unlock_B_runcnt", 32'(runCntB), 32'h0);
        checkOutput("unlock_B_status", 32'(statusB), 32'h0);
        checkOutput("unlock_B_failmask", 32'(failMaskB), 32'h0);
        checkOutput("unlock_B_chrst", 32'(chRstB), 32'hF);

        // Ch2 reports FAIL then PASS; FAIL must stick.
        relock();
        applyStimulus(0, 3'd2, 0, 0);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ch2fail_A_status", 32'(statusA), 32'h2);
        checkOutput("ch2fail_A_failmask", 32'(failMaskA), 32'h4);
        checkOutput("ch2fail_A_done", 32'(doneA), 32'h1);
        checkOutput("ch2fail_B_runcnt", 32'(runCntB), 32'h1);
        for (int k = 0; k < 4; k++) tick();

        // Lock lost in the middle of run 2 of dutB.
        applyStimulus(0, 0, 0, 1);
        locked = 1'b0;
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("midrun_B_chrst_e2", 32'(chRstB), 32'h0);
        tick();
        checkOutput("midrun_B_chrst", 32'(chRstB), 32'hF);
        checkOutput("midrun_B_runcnt", 32'(runCntB), 32'h0);
        checkOutput("midrun_B_status", 32'(statusB), 32'h0);
        checkOutput("midrun_B_failmask", 32'(failMaskB), 32'h0);
        checkOutput("midrun_A_done", 32'(doneA), 32'h0);

        relock();
        applyStimulus(1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("restart_B_runcnt", 32'(runCntB), 32'h1);
        checkOutput("restart_B_status", 32'(statusB), 32'h1);
        checkOutput("restart_A_status", 32'(statusA), 32'h1);
        checkOutput("restart_A_done", 32'(doneA), 32'h1);

        // Ch3 never reports.
        dropLock();
        relock();
        for (int c = 1; c <= 17; c++) applyStimulus(0, 1, 1, 1);
`ifdef GOLDEN_TEST_TIMEOUT_EN
        checkOutput("silent_A_status", 32'(statusA), 32'h3);
        checkOutput("silent_A_failmask", 32'(failMaskA), 32'h8);
        checkOutput("silent_A_done", 32'(doneA), 32'h1);
        checkOutput("silent_B_status", 32'(statusB), 32'h3);
        checkOutput("silent_B_runcnt", 32'(runCntB), 32'h1);
`else
        for (int c = 0; c < 8; c++) applyStimulus(0, 1, 1, 1);
        checkOutput("silent_A_status", 32'(statusA), 32'h0);
        checkOutput("silent_A_failmask", 32'(failMaskA), 32'h0);
        checkOutput("silent_A_done", 32'(doneA), 32'h0);
        checkOutput("silent_A_chrst", 32'(chRstA), 32'h0);
        checkOutput("silent_B_runcnt", 32'(runCntB), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/golden_test_ctrl.md
GOLDEN_TEST_CTRL -- requirements
Module: golden_test_ctrl

Interface
REQ-001 Parameter N_CH, 4, number of golden-test channels (1..16).
REQ-002 Parameter RESET_DELAY, 4, cycles of stable lock before channel resets release (>=1).
REQ-003 Parameter TIMEOUT_CYCLES, 1000000, maximum RUN length per run (>=2).
REQ-004 Parameter N_RUNS, 1, back-to-back runs per lock (>=1).
REQ-005 clk  input  1  single clock; every flop is clocked on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 locked  input  1  PLL lock, asynchronous to clk.
REQ-008 ch_result  input  N_CH x 3  per-channel comparator result code.
REQ-009 ch_rst  output  N_CH  registered active-high reset to each channel under test.
REQ-010 status  output  3  aggregated result code.
REQ-011 fail_mask  output  N_CH  sticky per-channel non-pass flag.
REQ-012 run_cnt  output  $clog2(N_RUNS+1)  completed runs.
REQ-013 done  output  1  all N_RUNS complete.

Function
REQ-014 Result codes SHALL be: RES_RUNNING=0, RES_PASS=1, RES_FAIL=2, RES_TIMEOUT=3; codes 4..7 SHALL be treated as FAIL.
REQ-015 locked SHALL pass through a 2-flop synchronizer; lock_s is the synchronized value (2-cycle latency).
REQ-016 FSM states SHALL be IDLE, HOLD, RUN, EVAL, DONE.
REQ-017 IDLE: ch_rst all 1; lock_s=1 -> HOLD with delay counter cleared.
REQ-018 HOLD: ch_rst all 1; counter increments per cycle; when it reaches RESET_DELAY-1 -> RUN; ch_rst drops to all 0 on the first RUN cycle (exactly RESET_DELAY HOLD cycles).
REQ-019 RUN: each channel SHALL latch its first ch_result != RES_RUNNING; later changes are ignored until the next run.
REQ-020 RUN -> EVAL when every channel is latched, or on timeout (REQ-029); simultaneous last-latch and timeout SHALL count as all latched (no timeout).
REQ-021 EVAL (one cycle): run result = FAIL if any latched FAIL, else TIMEOUT if any unlatched, else PASS; fail_mask |= channels not PASS; run_cnt increments.
REQ-022 status SHALL be RES_RUNNING until the first EVAL, then the sticky worst run result, ordered FAIL > TIMEOUT > PASS.
REQ-023 EVAL -> HOLD (ch_rst all 1, latches cleared) if run_cnt < N_RUNS after increment, else DONE.
REQ-024 DONE: ch_rst all 0, done=1, outputs frozen until rst or lock loss.
REQ-025 lock_s=0 in any state SHALL force IDLE next cycle: ch_rst all 1, latches, counters, run_cnt, done, status, fail_mask cleared.
REQ-026 run_cnt SHALL saturate at N_RUNS; no wrap.

Reset
REQ-027 rst=1 SHALL on the next edge set: state IDLE, synchronizer 0, ch_rst all 1, status RES_RUNNING, fail_mask 0, run_cnt 0, done 0, all counters 0.
REQ-028 rst mid-RUN SHALL discard partial latches; no EVAL occurs.

Configuration
REQ-029 Macro GOLDEN_TEST_TIMEOUT_EN defined: counter of $clog2(TIMEOUT_CYCLES) bits clears on entering RUN, increments in RUN, timeout when it equals TIMEOUT_CYCLES-1; not defined: no counter, RUN waits indefinitely, RES_TIMEOUT never produced.

Structure
REQ-030 Package golden_test_pkg SHALL hold the result-code enum (3 bits), FSM state enum, and result-priority function.
REQ-031 One sub-module, lock_sync (2-flop synchronizer with synchronous rst), SHALL be instantiated; everything else SHALL reside in golden_test_ctrl.

Verification
REQ-032 N_CH=4, RESET_DELAY=4: rst, then locked=1 -> ch_rst=4'hF held, released exactly 2+1+4 cycles after locked rises (sync + IDLE->HOLD + HOLD count).
REQ-033 Channels report PASS at RUN cycles 3,5,7,9 -> status=1, fail_mask=0, run_cnt=1, done=1 two cycles after last PASS.
REQ-034 Ch2 reports FAIL then PASS -> ch2 latched FAIL, status=2, fail_mask=4'b0100.
REQ-035 With GOLDEN_TEST_TIMEOUT_EN, TIMEOUT_CYCLES=16, ch3 silent -> status=3, fail_mask=4'b1000 after 16 RUN cycles; without macro -> status stays 0, done=0.
REQ-036 N_RUNS=3, run1 PASS, run2 FAIL on ch0, run3 PASS -> ch_rst re-asserted for 4 cycles between runs, final status=2, fail_mask=4'b0001, run_cnt=3.
REQ-037 locked drops mid-RUN of run 2 -> within 3 cycles ch_rst=4'hF, run_cnt=0, status=0; relock restarts from run 1.
